// File: rtl/adc_threshold_trigger.sv
// Per-channel trigger qualifier. It fills the pre-trigger history, confirms a run of
// over-threshold samples, counts the post-trigger samples, then latches until rearm.
module adc_threshold_trigger #(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned MIDSCALE     = 512,
    parameter int unsigned CONFIRM      = 4,
    parameter int unsigned PRE_SAMPLES  = 512,
    parameter int unsigned POST_SAMPLES = 1536
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [15:0]       threshold,
    input  logic              enable,
    input  logic              rearm,
    output logic              trigger,
    output logic              trigger_persistent,
    output logic              send_frame,
    output logic              armed,
    output logic [DATA_W-1:0] peak,
    output logic [2:0]        state_dbg
);

    localparam int unsigned PRE_W  = $clog2(PRE_SAMPLES + 1);
    localparam int unsigned RUN_W  = $clog2(CONFIRM + 1);
    localparam int unsigned POST_W = $clog2(POST_SAMPLES + 1);

    typedef enum logic [2:0] {
        FILL    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [POST_W-1:0]   post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0]   peak_q, peak_d;
    logic                trig_q, trig_d;
    logic                pers_q, pers_d;
    logic                send_q, send_d;
    logic                armed_q, armed_d;

    logic [DATA_W-1:0]   mid;
    logic [DATA_W-1:0]   mag;
    logic                over;

    assign mid  = DATA_W'(MIDSCALE);
    assign mag  = (sample_in >= mid) ? (sample_in - mid) : (mid - sample_in);
    // Both sides widened so any threshold above full-scale magnitude never trips.
    assign over = 32'(mag) > 32'(threshold);

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        run_cnt_d  = run_cnt_q;
        post_cnt_d = post_cnt_q;
        peak_d     = peak_q;
        pers_d     = pers_q;
        trig_d     = 1'b0;
        send_d     = 1'b0;

        case (state_q)
            FILL: begin
                if (!enable) begin
                    pre_cnt_d = '0;
                end else if (sample_valid) begin
                    if (pre_cnt_q == PRE_W'(PRE_SAMPLES - 1)) begin
                        state_d   = ARMED;
                        pre_cnt_d = '0;
                        run_cnt_d = '0;
                    end else begin
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d   = FILL;
                    pre_cnt_d = '0;
                    run_cnt_d = '0;
                end else if (sample_valid) begin
                    if (!over) begin
                        run_cnt_d = '0;
                    end else if (run_cnt_q == RUN_W'(CONFIRM - 1)) begin
                        state_d    = CAPTURE;
                        run_cnt_d  = '0;
                        post_cnt_d = '0;
                        peak_d     = mag;
                        trig_d     = 1'b1;
                        pers_d     = 1'b1;
                    end else begin
                        run_cnt_d = run_cnt_q + RUN_W'(1);
                    end
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    if (mag > peak_q) begin
                        peak_d = mag;
                    end
                    if (post_cnt_q == POST_W'(POST_SAMPLES - 1)) begin
                        state_d    = SEND;
                        post_cnt_d = '0;
                        send_d     = 1'b1;
                    end else begin
                        post_cnt_d = post_cnt_q + POST_W'(1);
                    end
                end
            end
            SEND: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (rearm) begin
                    state_d   = FILL;
                    pers_d    = 1'b0;
                    pre_cnt_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= FILL;
            pre_cnt_q  <= '0;
            run_cnt_q  <= '0;
            post_cnt_q <= '0;
            peak_q     <= '0;
            trig_q     <= 1'b0;
            pers_q     <= 1'b0;
            send_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            run_cnt_q  <= run_cnt_d;
            post_cnt_q <= post_cnt_d;
            peak_q     <= peak_d;
            trig_q     <= trig_d;
            pers_q     <= pers_d;
            send_q     <= send_d;
            armed_q    <= armed_d;
        end
    end

    assign trigger            = trig_q;
    assign trigger_persistent = pers_q;
    assign send_frame         = send_q;
    assign armed              = armed_q;
    assign peak               = peak_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_adc_threshold_trigger.sv
// Directed bench for adc_threshold_trigger with PRE=4, CONFIRM=2, POST=8.
module tb_adc_threshold_trigger;

    logic       clk;
    logic       reset_b;
    logic [9:0] sample_in;
    logic       sample_valid;
    logic [15:0] threshold;
    logic       enable;
    logic       rearm;
    logic       trigger;
    logic       trigger_persistent;
    logic       send_frame;
    logic       armed;
    logic [9:0] peak;
    logic [2:0] state_dbg;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    adc_threshold_trigger #(
        .DATA_W(10),
        .MIDSCALE(512),
        .CONFIRM(2),
        .PRE_SAMPLES(4),
        .POST_SAMPLES(8)
    ) dut (
        .clk(clk),
        .reset_b(reset_b),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .threshold(threshold),
        .enable(enable),
        .rearm(rearm),
        .trigger(trigger),
        .trigger_persistent(trigger_persistent),
        .send_frame(send_frame),
        .armed(armed),
        .peak(peak),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the sample consumed.
    task automatic smp(input int unsigned v);
        sample_in    = 10'(v);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trig"}, trigger, 0);
        check({tag, "_pers"}, trigger_persistent, 0);
        check({tag, "_send"}, send_frame, 0);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_peak"}, peak, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        reset_b      = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        threshold    = 16'd100;
        enable       = 1'b1;
        rearm        = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_b = 1'b1;

        // pre-history fill
        for (int i = 0; i < 3; i++) begin
            smp(900);
            check("fill_armed", armed, 0);
            check("fill_trig", trigger, 0);
        end
        smp(900);
        check("fill4_armed", armed, 1);
        check("fill4_state", state_dbg, 1);

        // qualification with a broken run
        smp(700);
        check("q1_trig", trigger, 0);
        smp(500);
        check("q2_trig", trigger, 0);
        smp(700);
        check("q3_trig", trigger, 0);
        smp(700);
        check("q4_trig", trigger, 1);
        check("q4_pers", trigger_persistent, 1);
        check("q4_armed", armed, 0);
        check("q4_state", state_dbg, 2);
        check("q4_peak", peak, 188);
        idle();
        check("q_trig_width", trigger, 0);
        check("q_pers_hold", trigger_persistent, 1);

        // rearm ignored during capture
        pulse_rearm();
        check("cap_rearm_state", state_dbg, 2);
        check("cap_rearm_pers", trigger_persistent, 1);

        // capture 8 samples, including full-scale deviation
        smp(600);
        smp(0);
        check("cap_peak512", peak, 512);
        for (int i = 0; i < 5; i++) smp(512);
        check("cap7_state", state_dbg, 2);
        check("cap7_send", send_frame, 0);
        smp(1023);
        check("cap8_send", send_frame, 1);
        check("cap8_state", state_dbg, 3);
        check("cap8_peak", peak, 512);
        idle();
        check("send_width", send_frame, 0);
        check("hold_state", state_dbg, 4);
        smp(1023);
        check("hold_peak", peak, 512);
        check("hold_state2", state_dbg, 4);
        check("hold_pers", trigger_persistent, 1);

        // rearm from hold
        pulse_rearm();
        check("rearm_pers", trigger_persistent, 0);
        check("rearm_state", state_dbg, 0);
        check("rearm_peak", peak, 512);
        for (int i = 0; i < 3; i++) smp(512);
        check("refill3_armed", armed, 0);
        smp(512);
        check("refill4_armed", armed, 1);

        // strict threshold boundary
        threshold = 16'd188;
        for (int i = 0; i < 5; i++) begin
            smp(700);
            check("thr_eq_trig", trigger, 0);
        end
        check("thr_eq_state", state_dbg, 1);
        smp(701);
        check("thr_a_trig", trigger, 0);
        smp(701);
        check("thr_b_trig", trigger, 1);
        check("thr_b_peak", peak, 189);
        for (int i = 0; i < 8; i++) smp(512);
        check("thr_send", send_frame, 1);
        check("thr_cap_peak", peak, 189);
        idle();
        pulse_rearm();
        check("thr_rearm_state", state_dbg, 0);

        // enable low while armed
        threshold = 16'd100;
        for (int i = 0; i < 4; i++) smp(512);
        check("en_armed", armed, 1);
        enable = 1'b0;
        idle();
        check("en_off_state", state_dbg, 0);
        check("en_off_armed", armed, 0);
        smp(512);
        check("en_off_fill", armed, 0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) smp(512);
        check("en_refill3", armed, 0);
        smp(512);
        check("en_refill4", armed, 1);

        // asynchronous reset mid-capture
        smp(700);
        smp(700);
        check("ar_trig", trigger, 1);
        smp(700);
        smp(700);
        check("ar_cap_state", state_dbg, 2);
        #2;
        reset_b = 1'b0;
        #1;
        check_all_zero("areset");
        @(negedge clk);
        reset_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp(512);
            check("ar_no_send", send_frame, 0);
        end
        check("ar_armed", armed, 1);
        check("ar_state", state_dbg, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_threshold_trigger.md
# adc_threshold_trigger

Per-channel trigger qualifier that sits between an SPI ADC receiver and the ring buffers. It watches the 10-bit offset-binary sample stream and, after a full pre-trigger history has accumulated, declares a trigger when the sample deviation from midscale exceeds a programmable threshold for a set number of consecutive samples. It then holds the ring buffers in triggered mode and, after a post-trigger sample count, pulses a send-frame request. It stays latched until software re-arms it.

## Interface
- DATA_W, 10, ADC sample width (offset binary)
- MIDSCALE, 512, zero-signal code subtracted from each sample
- CONFIRM, 4, consecutive over-threshold samples required to trigger (≥1)
- PRE_SAMPLES, 512, valid samples required after arming before trigger is allowed (≥1)
- POST_SAMPLES, 1536, valid samples captured after trigger before send_frame (≥1)
- clk  in  1  system clock; single clock domain
- reset_b  in  1  asynchronous, active-low reset
- sample_in  in  DATA_W  ADC sample; sampled only when sample_valid=1
- sample_valid  in  1  one-cycle strobe per new sample
- threshold  in  16  magnitude threshold, unsigned, compared zero-extended
- enable  in  1  allows arming; low holds block in FILL
- rearm  in  1  one-cycle strobe; releases HOLD
- trigger  out  1  one-cycle pulse on trigger declaration
- trigger_persistent  out  1  high from trigger until rearm accepted
- send_frame  out  1  one-cycle pulse when post-trigger capture completes
- armed  out  1  high in ARMED state
- peak  out  DATA_W  largest magnitude seen from trigger to end of capture
- state_dbg  out  3  encoded state: FILL=0, ARMED=1, CAPTURE=2, SEND=3, HOLD=4

## Operation
- Magnitude: mag = sample_in ≥ MIDSCALE ? sample_in−MIDSCALE : MIDSCALE−sample_in; DATA_W bits, max 512 fits. Over = {6'b0,mag} > threshold (strict). threshold=0 trips on any nonzero deviation; threshold ≥ 512 never trips.
- FILL: count valid samples in pre_cnt. When enable=1 and the PRE_SAMPLES-th valid sample arrives -> ARMED, run_cnt=0. enable=0 clears pre_cnt and stays in FILL.
- ARMED: each valid sample: if over, run_cnt++; else run_cnt=0. When run_cnt reaches CONFIRM (the CONFIRM-th consecutive over sample) -> CAPTURE; pulse trigger, set trigger_persistent, load peak=mag of that sample, post_cnt=0. enable=0 -> FILL, counters cleared.
- CAPTURE: each valid sample: post_cnt++, peak=max(peak,mag). On the POST_SAMPLES-th valid sample -> SEND. enable and rearm are ignored.
- SEND: one cycle; send_frame=1 -> HOLD.
- HOLD: trigger_persistent stays 1 and peak is frozen. rearm=1 -> FILL: trigger_persistent=0, pre_cnt=0, peak retained until next trigger. Samples are ignored.
- rearm in any state other than HOLD is ignored. sample_valid in SEND/HOLD is ignored.
- Counter widths: $clog2(param+1).

## Timing
- All outputs are registered. Reset values: trigger=0, trigger_persistent=0, send_frame=0, armed=0, peak=0, state_dbg=0 (FILL). All counters are 0.
- The cycle with sample_valid=1 is edge E. State and count updates are visible after E.
- Trigger latency: trigger and trigger_persistent go high on the cycle after the qualifying sample_valid. trigger lasts exactly 1 cycle.
- armed goes high the cycle after the PRE_SAMPLES-th valid sample. It goes low the same cycle trigger rises.
- send_frame goes high the cycle after the POST_SAMPLES-th post-trigger valid sample. It is 1 cycle wide. HOLD follows in the next cycle.
- rearm in HOLD: trigger_persistent is low the following cycle.
- Back-to-back sample_valid on every cycle is supported. No throughput stall.
- Asynchronous reset mid-operation immediately returns all outputs to reset values, including mid-CAPTURE. Pre-history must then refill.
- The trigger sample itself counts as a trigger, not as a post-trigger sample.

## Test plan
- Reset/fill (PRE=4, CONFIRM=2, POST=8, threshold=100): feed 3 samples of 900 -> no trigger, armed=0. The 4th valid sample -> armed=1 next cycle.
- Qualify: when armed, feed 700, 500, 700, 700 -> run resets at 500. trigger pulses once, the cycle after the 4th sample. peak=188. trigger_persistent=1.
- Threshold edge: threshold=188, sample 700 (mag 188) x5 -> no trigger. 701 x2 -> trigger.
- Capture/send: after trigger, 8 valid samples including 0 (mag 512) -> peak=512. send_frame is a 1-cycle pulse after the 8th sample. state_dbg=4 after that. Further samples do not change peak.
- Rearm/enable: rearm during CAPTURE is ignored. rearm in HOLD -> trigger_persistent=0, state_dbg=0, with 4 samples needed before armed. With enable=0 in ARMED -> state_dbg=0.
- Async reset: assert reset_b=0 mid-CAPTURE between clock edges -> all outputs are 0 immediately. No send_frame after release.
